// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: skid-stage state encoding and helpers.
// Other pipeline boundaries import this package so they agree on the encoding.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } pipe_state_e;

  // Number of entries held in a given state.
  function automatic logic [1:0] state_occupancy(input pipe_state_e st);
    logic [1:0] occ;
    case (st)
      ST_ONE:  occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between pipeline stages. All handshake outputs are
// decoded from registered state, breaking ready/valid combinational paths.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             push, pop;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_occupancy(state_q);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end
    endcase

    // Flush wins: any accepted push or completed pop this cycle is dropped.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits, legal range 1..256.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port flush  input  1  synchronous kill of all held entries (branch/trap redirect).
REQ-005 SHALL have port in_valid  input  1  upstream offers in_data this cycle.
REQ-006 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload (packed stage control and data fields).
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-009 SHALL have port out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  head entry payload.
REQ-011 SHALL have port occupancy  output  2  number of held entries, 0..2.

Function
REQ-012 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready, both evaluated before the clock edge.
REQ-013 SHALL implement a three-state machine: EMPTY (0 entries), ONE (1 entry, in main register), FULL (2 entries, main plus skid register).
REQ-014 SHALL transition EMPTY: push -> ONE with main<=in_data; otherwise stay.
REQ-015 SHALL transition ONE: push&pop -> ONE with main<=in_data; push only -> FULL with skid<=in_data; pop only -> EMPTY; neither -> stay.
REQ-016 SHALL transition FULL: pop -> ONE with main<=skid; otherwise stay; no push is possible in FULL.
REQ-017 SHALL drive in_ready = (state != FULL) and out_valid = (state != EMPTY), both decoded from registered state only; no combinational path from out_ready to in_ready or from in_valid to out_valid.
REQ-018 SHALL drive out_data directly from the main register; occupancy = 0/1/2 for EMPTY/ONE/FULL.
REQ-019 SHALL deliver entries in acceptance order; no entry is duplicated or dropped except by flush or reset.
REQ-020 SHALL have latency 1: an entry pushed at edge N is on out_data with out_valid=1 after edge N when the stage was EMPTY, or ONE with a simultaneous pop.
REQ-021 SHALL sustain one push and one pop per cycle indefinitely while out_ready is held at 1.
REQ-022 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL give flush priority over push and pop: next state EMPTY, main and skid cleared to 0; a push in the flush cycle is accepted (in_ready is 1 if not FULL) and discarded.
REQ-024 SHALL treat a pop in the flush cycle as completed; the downstream consumes the current out_data once.

Reset
REQ-025 SHALL, while rst=1, force state EMPTY, main=0, skid=0, out_valid=0, occupancy=0, out_data=0, in_ready=1, independent of clk.
REQ-026 SHALL ignore in_valid, out_ready and flush while rst=1; on the first edge after deassertion, behave per REQ-014.
REQ-027 SHALL discard any held entries when rst asserts mid-operation; no partial payload survives.

Structure
REQ-028 SHALL take state encodings (ST_EMPTY=2'b00, ST_ONE=2'b01, ST_FULL=2'b10) from the shared pipeline package pipe_pkg, for reuse by other pipeline stages.
REQ-029 SHALL be a single module without sub-modules; each of the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries instantiates one copy with WIDTH set to its packed field width.

Verification
REQ-030 SHALL cover streaming: WIDTH=32, out_ready=1, push 0x1..0x8 back-to-back -> out_data 0x1..0x8 on consecutive cycles one cycle later, occupancy stays 1, in_ready stays 1.
REQ-031 SHALL cover backpressure: out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0, out_data=0xA held; 0xC held at in_data is not accepted; raise out_ready -> 0xA, 0xB, 0xC in order.
REQ-032 SHALL cover flush: FULL with 0xA/0xB, flush=1 with in_valid=1 and in_data=0xC -> next cycle out_valid=0, occupancy 0, out_data=0, and 0xC never appears.
REQ-033 SHALL cover mid-stream reset: occupancy 2, assert rst between clock edges -> out_valid=0 and in_ready=1 immediately; after release, first push 0x5 -> out_data 0x5 one cycle later.
REQ-034 SHALL cover random stress: WIDTH=1 and WIDTH=256, random in_valid/out_ready/flush for 10^5 cycles against a scoreboard queue -> order preserved, no loss except by flush, REQ-022 never violated.
